// File: rtl/uart_rx_engine.sv
// ---------------------------------------------------------------------------
// UartRxEngine -- UART byte receiver (receive-side partner of uart_engine).
//
// Frame format: idle high, one start bit (low), eight data bits LSB first,
// one stop bit (high). CLKS_PER_BIT sets the bit period in clk cycles; the
// default of 1 matches the TX engine so a direct loopback works.
//
// Ports:
//   clk           in   1  rising-edge clock
//   reset_n       in   1  asynchronous, active-low reset
//   rx_line       in   1  serial input, may be asynchronous to clk
//   rx_data       out  8  last received byte, stable while rx_valid=1
//   rx_valid      out  1  rx_data holds a byte not yet consumed
//   rx_ack        in   1  consumer takes rx_data when rx_valid&rx_ack
//   rx_busy       out  1  receiver is somewhere inside a frame
//   rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
//   rx_overrun    out  1  one-cycle pulse: byte arrived while holding reg full
// ---------------------------------------------------------------------------
module uart_rx_engine #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    // HALF is the sample offset into the start bit; later samples then land
    // one full bit period apart, i.e. near the middle of each bit.
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMR_BIT  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMR_HALF = (HALF > 0) ? TW'(HALF - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;
    logic [TW-1:0]   r_tmr;
    logic [TW-1:0]   w_tmr_n;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_n;
    logic [7:0]      r_sh;
    logic [7:0]      w_sh_n;
    logic            w_deliver;
    logic            w_ferr;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;

    // Two-flop synchroniser; both flops reset high so a reset never looks
    // like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_line;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Frame state register plus the bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_idx   <= 3'd0;
            r_sh    <= 8'h00;
        end else begin
            r_state <= w_state_n;
            r_tmr   <= w_tmr_n;
            r_idx   <= w_idx_n;
            r_sh    <= w_sh_n;
        end
    end

    // Next-state logic. The timer counts down; each state acts when it hits
    // zero. BREAK exists so that a line stuck low after a bad stop bit is not
    // mistaken for a stream of new start bits.
    always_comb begin
        w_state_n = r_state;
        w_tmr_n   = r_tmr;
        w_idx_n   = r_idx;
        w_sh_n    = r_sh;
        w_deliver = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    if (HALF == 0) begin
                        w_state_n = ST_DATA;
                        w_tmr_n   = TMR_BIT;
                        w_idx_n   = 3'd0;
                    end else begin
                        w_state_n = ST_START;
                        w_tmr_n   = TMR_HALF;
                    end
                end
            end
            ST_START: begin
                if (r_tmr != '0) begin
                    w_tmr_n = r_tmr - TW'(1);
                end else if (!w_rx_s) begin
                    w_state_n = ST_DATA;
                    w_tmr_n   = TMR_BIT;
                    w_idx_n   = 3'd0;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (r_tmr != '0) begin
                    w_tmr_n = r_tmr - TW'(1);
                end else begin
                    w_sh_n[r_idx] = w_rx_s;
                    w_tmr_n       = TMR_BIT;
                    w_idx_n       = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_tmr != '0) begin
                    w_tmr_n = r_tmr - TW'(1);
                end else if (w_rx_s) begin
                    w_deliver = 1'b1;
                    w_state_n = ST_IDLE;
                end else begin
                    w_ferr    = 1'b1;
                    w_state_n = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_rx_s) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // One-entry holding register. A byte arriving in the same cycle as an
    // ack replaces the consumed one; otherwise a full register keeps the old
    // byte and flags the overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || rx_ack) begin
                    r_data  <= r_sh;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_busy      = (r_state != ST_IDLE);
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_engine -- testbench for uart_rx_engine.
// Instantiates one receiver at CLKS_PER_BIT=1 and one at CLKS_PER_BIT=4.
// Single-frame vectors come from a table; back-to-back, overrun, break,
// glitch and mid-frame reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_uart_rx_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       line1;
    logic       line4;
    logic       ack1;
    logic       ack4;
    logic [7:0] rx_data1;
    logic       rx_valid1;
    logic       rx_busy1;
    logic       rx_frame_err1;
    logic       rx_overrun1;
    logic [7:0] rx_data4;
    logic       rx_valid4;
    logic       rx_busy4;
    logic       rx_frame_err4;
    logic       rx_overrun4;

    always #5 clk = ~clk;

    uart_rx_engine u_dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_line      (line1),
        .rx_data      (rx_data1),
        .rx_valid     (rx_valid1),
        .rx_ack       (ack1),
        .rx_busy      (rx_busy1),
        .rx_frame_err (rx_frame_err1),
        .rx_overrun   (rx_overrun1)
    );

    uart_rx_engine #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_line      (line4),
        .rx_data      (rx_data4),
        .rx_valid     (rx_valid4),
        .rx_ack       (ack4),
        .rx_busy      (rx_busy4),
        .rx_frame_err (rx_frame_err4),
        .rx_overrun   (rx_overrun4)
    );

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         expRise;
        int         expFe;
    } vec_t;

    vec_t vecs[7];

    int   nVec = 0;
    int   nMis = 0;
    int   cyc = 0;
    int   stopCyc = 0;
    logic ackMode = 1'b0;

    // Event monitor: counts valid rising edges (logging the byte and the
    // cycle), frame-error pulses and overrun pulses, sampled mid-cycle.
    int         rises1 = 0;
    int         fe1 = 0;
    int         ov1 = 0;
    int         riseCyc1 = 0;
    logic       prevV1 = 1'b0;
    logic [7:0] rxQ1[$];
    int         rises4 = 0;
    int         fe4 = 0;
    int         ov4 = 0;
    logic       prevV4 = 1'b0;
    logic [7:0] lastData4 = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid1 === 1'b1 && prevV1 !== 1'b1) begin
            rises1++;
            riseCyc1 = cyc;
            rxQ1.push_back(rx_data1);
        end
        prevV1 = rx_valid1;
        if (rx_frame_err1 === 1'b1) fe1++;
        if (rx_overrun1 === 1'b1) ov1++;
        if (rx_valid4 === 1'b1 && prevV4 !== 1'b1) begin
            rises4++;
            lastData4 = rx_data4;
        end
        prevV4 = rx_valid4;
        if (rx_frame_err4 === 1'b1) fe4++;
        if (rx_overrun4 === 1'b1) ov4++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVec++;
        if (actual != expected) begin
            nMis++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // One clock; inputs change 1 time unit after the rising edge. In ack
    // mode the consumer acks in the very cycle rx_valid becomes visible.
    task automatic step();
        @(posedge clk);
        #1;
        ack1 = ackMode & rx_valid1;
    endtask

    task automatic driveLine(input int sel, input logic v);
        if (sel == 4) line4 = v;
        else line1 = v;
    endtask

    task automatic sendFrame(input int sel, input logic [7:0] d, input logic stopBit);
        int cpb;
        cpb = (sel == 4) ? 4 : 1;
        driveLine(sel, 1'b0);
        repeat (cpb) step();
        for (int i = 0; i < 8; i++) begin
            driveLine(sel, d[i]);
            repeat (cpb) step();
        end
        driveLine(sel, stopBit);
        stopCyc = cyc;
        repeat (cpb) step();
    endtask

    task automatic applyStimulus(input vec_t v);
        sendFrame(1, v.data, v.stopBit);
        line1 = 1'b1;
        repeat (8) step();
    endtask

    initial begin
        int r0;
        int f0;
        int o0;
        int q0;
        logic sawBusy;

        vecs[0] = '{data: 8'hDA, stopBit: 1'b1, expRise: 1, expFe: 0};
        vecs[1] = '{data: 8'h00, stopBit: 1'b1, expRise: 1, expFe: 0};
        vecs[2] = '{data: 8'hFF, stopBit: 1'b1, expRise: 1, expFe: 0};
        vecs[3] = '{data: 8'h01, stopBit: 1'b1, expRise: 1, expFe: 0};
        vecs[4] = '{data: 8'h80, stopBit: 1'b1, expRise: 1, expFe: 0};
        vecs[5] = '{data: 8'h55, stopBit: 1'b0, expRise: 0, expFe: 1};
        vecs[6] = '{data: 8'hAA, stopBit: 1'b1, expRise: 1, expFe: 0};

        reset_n = 1'b0;
        line1   = 1'b1;
        line4   = 1'b1;
        ack1    = 1'b0;
        ack4    = 1'b0;
        repeat (3) step();
        checkOutput("reset rx_valid", int'(rx_valid1), 0);
        checkOutput("reset rx_data", int'(rx_data1), 0);
        checkOutput("reset rx_busy", int'(rx_busy1), 0);
        checkOutput("reset rx_frame_err", int'(rx_frame_err1), 0);
        checkOutput("reset rx_overrun", int'(rx_overrun1), 0);
        checkOutput("reset cpb4 rx_valid", int'(rx_valid4), 0);
        reset_n = 1'b1;
        repeat (3) step();

        $display("[TB] table of single frames, consumer acking");
        ackMode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            r0 = rises1;
            f0 = fe1;
            o0 = ov1;
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d rx_valid rises", i), rises1 - r0, vecs[i].expRise);
            checkOutput($sformatf("vec%0d frame_err pulses", i), fe1 - f0, vecs[i].expFe);
            checkOutput($sformatf("vec%0d overrun pulses", i), ov1 - o0, 0);
            checkOutput($sformatf("vec%0d rx_valid after ack", i), int'(rx_valid1), 0);
            if (vecs[i].expRise == 1 && rises1 - r0 == 1) begin
                checkOutput($sformatf("vec%0d rx_data", i), int'(rxQ1[rxQ1.size() - 1]),
                            int'(vecs[i].data));
                checkOutput($sformatf("vec%0d latency", i), riseCyc1 - stopCyc, 3);
            end
        end

        $display("[TB] back-to-back frames 5E, A5");
        r0 = rises1;
        q0 = rxQ1.size();
        sendFrame(1, 8'h5E, 1'b1);
        sendFrame(1, 8'hA5, 1'b1);
        repeat (8) step();
        checkOutput("b2b rises", rises1 - r0, 2);
        if (rxQ1.size() >= q0 + 2) begin
            checkOutput("b2b first byte", int'(rxQ1[q0]), 8'h5E);
            checkOutput("b2b second byte", int'(rxQ1[q0 + 1]), 8'hA5);
        end

        $display("[TB] overrun: 11 unacked then 22");
        ackMode = 1'b0;
        r0 = rises1;
        o0 = ov1;
        sendFrame(1, 8'h11, 1'b1);
        repeat (3) step();
        sendFrame(1, 8'h22, 1'b1);
        repeat (8) step();
        checkOutput("overrun pulses", ov1 - o0, 1);
        checkOutput("overrun rises", rises1 - r0, 1);
        checkOutput("overrun rx_valid held", int'(rx_valid1), 1);
        checkOutput("overrun rx_data kept", int'(rx_data1), 8'h11);
        ack1 = 1'b1;
        step();
        checkOutput("ack clears rx_valid", int'(rx_valid1), 0);

        $display("[TB] framing error then line held low");
        r0 = rises1;
        f0 = fe1;
        sendFrame(1, 8'hC3, 1'b0);
        repeat (20) step();
        checkOutput("break rx_busy", int'(rx_busy1), 1);
        checkOutput("break frame_err pulses", fe1 - f0, 1);
        checkOutput("break rises", rises1 - r0, 0);
        line1 = 1'b1;
        repeat (4) step();
        checkOutput("break exit rx_busy", int'(rx_busy1), 0);
        sendFrame(1, 8'h3C, 1'b1);
        repeat (8) step();
        checkOutput("after break rises", rises1 - r0, 1);
        checkOutput("after break rx_data", int'(rx_data1), 8'h3C);
        checkOutput("after break rx_valid", int'(rx_valid1), 1);
        checkOutput("after break frame_err pulses", fe1 - f0, 1);

        $display("[TB] cpb4 glitch then frame 81");
        line4 = 1'b0;
        step();
        line4 = 1'b1;
        sawBusy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rx_busy4 === 1'b1) sawBusy = 1'b1;
        end
        checkOutput("glitch busy seen", int'(sawBusy), 1);
        checkOutput("glitch busy returns 0", int'(rx_busy4), 0);
        checkOutput("glitch no rx_valid", rises4, 0);
        checkOutput("glitch no frame_err", fe4, 0);
        sendFrame(4, 8'h81, 1'b1);
        repeat (12) step();
        checkOutput("cpb4 rises", rises4, 1);
        checkOutput("cpb4 rx_data", int'(lastData4), 8'h81);
        checkOutput("cpb4 overrun pulses", ov4, 0);

        $display("[TB] reset during data bit 4 of FF");
        r0 = rises1;
        f0 = fe1;
        line1 = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            line1 = 1'b1;
            step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid reset rx_valid", int'(rx_valid1), 0);
        checkOutput("mid reset rx_data", int'(rx_data1), 0);
        checkOutput("mid reset rx_busy", int'(rx_busy1), 0);
        checkOutput("mid reset rx_frame_err", int'(rx_frame_err1), 0);
        checkOutput("mid reset rx_overrun", int'(rx_overrun1), 0);
        step();
        reset_n = 1'b1;
        repeat (8) step();
        checkOutput("post reset idle busy", int'(rx_busy1), 0);
        sendFrame(1, 8'h00, 1'b1);
        repeat (8) step();
        checkOutput("post reset rises", rises1 - r0, 1);
        checkOutput("post reset rx_valid", int'(rx_valid1), 1);
        checkOutput("post reset rx_data", int'(rx_data1), 8'h00);
        checkOutput("post reset frame_err pulses", fe1 - f0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
